// File: rtl/mult_seq_if.sv
// Handshake/operand bundle between the EX-stage ALU (master) and the
// sequential multiplier (slave).
interface mult_seq_if #(
  parameter int WIDTH = 32
);
  logic               signed_mult;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               start;
  logic               annul;
  logic [2*WIDTH-1:0] result;
  logic               ready;

  modport master (
    output signed_mult, opdata1, opdata2, start, annul,
    input  result, ready
  );

  modport slave (
    input  signed_mult, opdata1, opdata2, start, annul,
    output result, ready
  );
endinterface

// File: rtl/mult_seq.sv
// Radix-2 shift-add MULT/MULTU unit with start/ready/annul handshake.
// Optional early completion when the multiplier runs out of set bits: MULT_EARLY_TERM_EN.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  mult_seq_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start, captures operands
  // ZERO  | an operand was zero, product is 0
  // ON    | one shift-add iteration per edge
  // END   | result valid, waits for start to drop
  typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state, state_n;
  logic [2*WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0]   mplier, mplier_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               sign_r, sign_n;
  logic [2*WIDTH-1:0] result_q, result_n;
  logic               ready_q, ready_n;

  logic [WIDTH-1:0]   mag1, mag2;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier_sh;
  logic               done;

  assign bus.result = result_q;
  assign bus.ready  = ready_q;

  // Signed magnitudes: the most negative value maps onto its unsigned magnitude.
  assign mag1 = (bus.signed_mult && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
  assign mag2 = (bus.signed_mult && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;

  assign acc_sum   = acc + (mplier[0] ? mcand : '0);
  assign mplier_sh = mplier >> 1;

`ifdef MULT_EARLY_TERM_EN
  assign done = (cnt == LAST) || (mplier_sh == '0);
`else
  assign done = (cnt == LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      sign_r   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_n;
      mcand    <= mcand_n;
      mplier   <= mplier_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      sign_r   <= sign_n;
      result_q <= result_n;
      ready_q  <= ready_n;
    end
  end

  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    cnt_n    = cnt;
    sign_n   = sign_r;
    result_n = result_q;
    ready_n  = ready_q;

    case (state)
      IDLE: begin
        if (bus.start && !bus.annul) begin
          sign_n   = bus.signed_mult & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
          mcand_n  = {{WIDTH{1'b0}}, mag1};
          mplier_n = mag2;
          acc_n    = '0;
          cnt_n    = '0;
          state_n  = (bus.opdata1 == '0 || bus.opdata2 == '0) ? ZERO : ON;
        end
      end

      ZERO: begin
        result_n = '0;
        if (bus.annul) begin
          ready_n = 1'b0;
          state_n = IDLE;
        end else begin
          ready_n = 1'b1;
          state_n = END;
        end
      end

      ON: begin
        if (bus.annul) begin
          acc_n    = '0;
          cnt_n    = '0;
          result_n = '0;
          ready_n  = 1'b0;
          state_n  = IDLE;
        end else begin
          acc_n    = acc_sum;
          mcand_n  = mcand << 1;
          mplier_n = mplier_sh;
          cnt_n    = cnt + 1'b1;
          if (done) begin
            result_n = sign_r ? -acc_sum : acc_sum;
            ready_n  = 1'b1;
            state_n  = END;
          end
        end
      end

      END: begin
        // Holding start keeps the result up so a stalled ALU cannot re-issue.
        if (bus.annul || !bus.start) begin
          result_n = '0;
          ready_n  = 1'b0;
          state_n  = IDLE;
        end
      end

      default: begin
        result_n = '0;
        ready_n  = 1'b0;
        state_n  = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_mult_seq.sv
// Randomised and directed check of mult_seq against an arithmetic product model.
module tb_mult_seq;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mult_seq_if bus ();

  mult_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] ua, ub;
    if (s) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return sp;
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  function automatic int exp_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    int          top;
    if (a == 0 || b == 0) return 1;
    m = (s && b[31]) ? (~b + 1) : b;
    top = 0;
    for (int i = 0; i < 32; i++) if (m[i]) top = i;
`ifdef MULT_EARLY_TERM_EN
    return top + 1;
`else
    return 32;
`endif
  endfunction

  // Issues one operation, checks latency/result, holds start for hold cycles, then releases.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int          n;
    logic        got;
    logic [63:0] exp;
    exp = model(s, a, b);
    @(negedge clk);
    bus.signed_mult = s;
    bus.opdata1     = a;
    bus.opdata2     = b;
    bus.start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.signed_mult = 1'($urandom);
    bus.opdata1     = $urandom;
    bus.opdata2     = $urandom;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ready === 1'b1) got = 1'b1;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat(s, a, b)));
    check({tag, "_res"}, bus.result, exp);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_rdy"}, {63'b0, bus.ready}, 64'd1);
      check({tag, "_hold_res"}, bus.result, exp);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_rel_rdy"}, {63'b0, bus.ready}, 64'd0);
    check({tag, "_rel_res"}, bus.result, 64'd0);
  endtask

  initial begin
    logic        rose;
    logic        rs;
    logic [31:0] ra, rb;
    vectors         = 0;
    miscompares     = 0;
    rst             = 1'b1;
    bus.signed_mult = 1'b0;
    bus.opdata1     = '0;
    bus.opdata2     = '0;
    bus.start       = 1'b0;
    bus.annul       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy", {63'b0, bus.ready}, 64'd0);
    check("reset_res", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max_const", model(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    run_op("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 0);
    run_op("mult_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mult_min_x1", 1'b1, 32'h8000_0000, 32'd1, 0);
    run_op("multu_min_x1", 1'b0, 32'h8000_0000, 32'd1, 0);
    run_op("zero_a", 1'b1, 32'd0, 32'h1234, 0);
    run_op("zero_b", 1'b0, 32'h1234, 32'd0, 0);

    // Annul after E10: no result may appear.
    @(negedge clk);
    bus.signed_mult = 1'b0;
    bus.opdata1     = 32'h10;
    bus.opdata2     = 32'h20;
    bus.start       = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.annul = 1'b0;
    rose = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready === 1'b1) rose = 1'b1;
    end
    check("annul_no_ready", {63'b0, rose}, 64'd0);
    run_op("after_annul", 1'b0, 32'd6, 32'd7, 0);

    // Synchronous reset at E15 mid-operation.
    @(negedge clk);
    bus.opdata1 = 32'h1234_5678;
    bus.opdata2 = 32'h9ABC_DEF1;
    bus.start   = 1'b1;
    @(posedge clk);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rdy", {63'b0, bus.ready}, 64'd0);
    check("midrst_res", bus.result, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    run_op("hold5", 1'b1, 32'hFFFF_FFF0, 32'h0000_0123, 5);

    run_op("et_7x3", 1'b0, 32'd7, 32'd3, 0);
    run_op("et_5xm1", 1'b1, 32'd5, 32'hFFFF_FFFF, 0);

    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 0;
      if ($urandom_range(0, 7) == 0) rb = rb >> $urandom_range(0, 31);
      run_op("rand", rs, ra, rb, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
